// File: rtl/apb_pkg.sv
// Shared definitions for APB completers: FSM state encoding, strobe width and address decode helper.
package apb_pkg;

  typedef enum logic [1:0] {
    APB_C_IDLE = 2'd0,
    APB_C_WAIT = 2'd1,
    APB_C_DONE = 2'd2
  } apb_c_state_e;

  localparam int unsigned APB_STRB_W = 4;

  // Word index from a byte address; the two low address bits are dropped.
  function automatic logic [31:0] apb_reg_idx(input logic [31:0] addr);
    return {2'b00, addr[31:2]};
  endfunction

endpackage

// File: rtl/apb_wait_counter.sv
// Wait-state counter for APB completers: load at setup, decrement per access cycle, flag terminal count.
module apb_wait_counter #(
  parameter int unsigned Width = 4
) (
  input  logic             HCLK,
  input  logic             HRESETn,
  input  logic             load_i,
  input  logic [Width-1:0] load_val_i,
  input  logic             dec_i,
  output logic             tc_o
);

  logic [Width-1:0] cnt_d, cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Terminal count is one: the last wait cycle hands over to the ready cycle.
  assign tc_o = (cnt_q == Width'(1));

endmodule

// File: rtl/apb_reg_completer.sv
// APB3/APB4 completer with a small register bank, programmable wait states, byte strobes and
// error response; register contents are exported as a flat vector with per-register write pulses.
module apb_reg_completer
  import apb_pkg::*;
#(
  parameter int unsigned ADDRWIDTH   = 16,
  parameter int unsigned DATAWIDTH   = 32,
  parameter int unsigned NUM_REGS    = 8,
  parameter int unsigned WAIT_CYCLES = 0,
  parameter logic [31:0] ID_VALUE    = 32'hA5B0_0001
) (
  input  logic                          HCLK,
  input  logic                          HRESETn,
  input  logic                          PCLKEN,
  input  logic                          PSEL,
  input  logic                          PENABLE,
  input  logic [ADDRWIDTH-1:0]          PADDR,
  input  logic                          PWRITE,
  input  logic [DATAWIDTH-1:0]          PWDATA,
  input  logic [APB_STRB_W-1:0]         PSTRB,
  input  logic [2:0]                    PPROT,
  output logic [DATAWIDTH-1:0]          PRDATA,
  output logic                          PREADY,
  output logic                          PSLVERR,
  output logic [NUM_REGS*DATAWIDTH-1:0] reg_out,
  output logic [NUM_REGS-1:0]           wr_pulse
);

  localparam int unsigned IdxW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

  apb_c_state_e         state_d, state_q;
  logic                 pready_d, pready_q;
  logic                 pslverr_d, pslverr_q;
  logic [DATAWIDTH-1:0] prdata_d, prdata_q;
  logic [NUM_REGS-1:0]  wr_pulse_d, wr_pulse_q;
  logic [DATAWIDTH-1:0] regs_d [NUM_REGS];
  logic [DATAWIDTH-1:0] regs_q [NUM_REGS];

  logic [31:0]          idx;
  logic [IdxW-1:0]      idx_l;
  logic                 err;
  logic [DATAWIDTH-1:0] rd_data;
  logic                 commit, cnt_load, cnt_dec, cnt_tc;
  logic                 unused_pprot;

  assign unused_pprot = ^PPROT;

  assign idx   = apb_reg_idx(32'(PADDR));
  assign idx_l = idx[IdxW-1:0];
  assign err   = (idx >= NUM_REGS) || (PWRITE && (idx == 32'd0));

  always_comb begin
    rd_data = '0;
    if (!err) begin
      rd_data = (idx_l == '0) ? ID_VALUE : regs_q[idx_l];
    end
  end

  apb_wait_counter #(
    .Width(4)
  ) u_wait_counter (
    .HCLK      (HCLK),
    .HRESETn   (HRESETn),
    .load_i    (cnt_load),
    .load_val_i(4'(WAIT_CYCLES)),
    .dec_i     (cnt_dec),
    .tc_o      (cnt_tc)
  );

  // All state advances only on PCLKEN; outputs are recomputed from the next state so they
  // appear registered and simply hold while PCLKEN is low.
  always_comb begin
    state_d   = state_q;
    pready_d  = pready_q;
    pslverr_d = pslverr_q;
    prdata_d  = prdata_q;
    commit    = 1'b0;
    cnt_load  = 1'b0;
    cnt_dec   = 1'b0;
    if (PCLKEN) begin
      unique case (state_q)
        APB_C_IDLE: begin
          if (PSEL && !PENABLE) begin
            cnt_load = 1'b1;
            state_d  = (WAIT_CYCLES == 0) ? APB_C_DONE : APB_C_WAIT;
          end
        end
        APB_C_WAIT: begin
          if (!PSEL) begin
            state_d = APB_C_IDLE;
          end else begin
            cnt_dec = 1'b1;
            if (cnt_tc) state_d = APB_C_DONE;
          end
        end
        APB_C_DONE: begin
          if (!PSEL) begin
            state_d = APB_C_IDLE;
          end else if (PENABLE) begin
            state_d = APB_C_IDLE;
            commit  = PWRITE && !err;
          end
        end
        default: state_d = APB_C_IDLE;
      endcase
      pready_d  = (state_d == APB_C_DONE);
      pslverr_d = pready_d && err;
      prdata_d  = (pready_d && !PWRITE) ? rd_data : '0;
    end
  end

  always_comb begin
    regs_d     = regs_q;
    wr_pulse_d = '0;
    if (commit) begin
      wr_pulse_d[idx_l] = 1'b1;
      for (int b = 0; b < APB_STRB_W; b++) begin
        if (PSTRB[b]) regs_d[idx_l][8*b +: 8] = PWDATA[8*b +: 8];
      end
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q    <= APB_C_IDLE;
      pready_q   <= 1'b0;
      pslverr_q  <= 1'b0;
      prdata_q   <= '0;
      wr_pulse_q <= '0;
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
    end else begin
      state_q    <= state_d;
      pready_q   <= pready_d;
      pslverr_q  <= pslverr_d;
      prdata_q   <= prdata_d;
      wr_pulse_q <= wr_pulse_d;
      regs_q     <= regs_d;
    end
  end

  always_comb begin
    reg_out = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      reg_out[i*DATAWIDTH +: DATAWIDTH] = (i == 0) ? ID_VALUE : regs_q[i];
    end
  end

  assign PRDATA   = prdata_q;
  assign PREADY   = pready_q;
  assign PSLVERR  = pslverr_q;
  assign wr_pulse = wr_pulse_q;

endmodule
